// File: rtl/kb_event_scheduler.sv
// rtl/kb_event_scheduler.sv - key event generator with typematic repeat and show-ahead event FIFO
module kb_event_scheduler #(
    parameter int DELAY_CYC  = 25000000,
    parameter int REPEAT_CYC = 12500000,
    parameter int DEPTH      = 16,
    parameter int AW         = 4
) (
    input  logic          CLOCK_50,
    input  logic          rst,
    input  logic [7:0]    ascii,
    input  logic [4:0]    mods,
    input  logic          pop,
    input  logic          clr_ovf,
    input  logic          irq_en,
    output logic [15:0]   rd_data,
    output logic          rd_valid,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          irq
);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    state_t      state, state_nxt;
    logic [31:0] timer, timer_nxt, term;
    logic [7:0]  held, held_nxt;
    logic [7:0]  ascii_q;
    logic [4:0]  mods_q;
    logic        push;

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count_r;
    logic          full, push_ok, pop_ok, drop;

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            ascii_q <= 8'h00;
            mods_q  <= 5'b0;
            state   <= IDLE;
            timer   <= 32'd0;
            held    <= 8'h00;
        end else begin
            ascii_q <= ascii;
            mods_q  <= mods;
            state   <= state_nxt;
            timer   <= timer_nxt;
            held    <= held_nxt;
        end
    end

    assign term = (state == DELAY) ? 32'(DELAY_CYC - 1) : 32'(REPEAT_CYC - 1);

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        held_nxt  = held;
        push      = 1'b0;
        // An error flag from the driver aborts any hold without emitting an event
        if (mods_q[4]) begin
            state_nxt = IDLE;
            timer_nxt = 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (ascii_q != 8'h00) begin
                        push      = 1'b1;
                        held_nxt  = ascii_q;
                        timer_nxt = 32'd0;
                        state_nxt = DELAY;
                    end
                end
                DELAY, REPEAT: begin
                    if (ascii_q == 8'h00) begin
                        state_nxt = IDLE;
                        timer_nxt = 32'd0;
                    end else if (ascii_q != held) begin
                        push      = 1'b1;
                        held_nxt  = ascii_q;
                        timer_nxt = 32'd0;
                        state_nxt = DELAY;
                    end else if (timer == term) begin
                        push      = 1'b1;
                        timer_nxt = 32'd0;
                        state_nxt = REPEAT;
                    end else begin
                        timer_nxt = timer + 32'd1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    timer_nxt = 32'd0;
                end
            endcase
        end
    end

    assign full    = (count_r == (AW+1)'(DEPTH));
    assign pop_ok  = pop && (count_r != '0);
    // A simultaneous pop frees the slot, so a full FIFO still accepts the push
    assign push_ok = push && (!full || pop_ok);
    assign drop    = push && full && !pop_ok;

    always_ff @(posedge CLOCK_50) begin
        if (push_ok) begin
            mem[wr_ptr] <= {3'b000, mods_q, ascii_q};
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_r  <= '0;
            overflow <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
            if (drop)         overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
            irq <= irq_en && rd_valid;
        end
    end

    assign rd_valid = (count_r != '0);
    assign count    = count_r;
    assign rd_data  = rd_valid ? mem[rd_ptr] : 16'h0000;

endmodule

// File: tb/tb_kb_event_scheduler.sv
// tb/tb_kb_event_scheduler.sv - bench for kb_event_scheduler with a queue-based reference model
module tb_kb_event_scheduler;

    localparam int DLY = 10;
    localparam int RPT = 4;
    localparam int DEP = 4;
    localparam int AWL = 2;

    logic          CLOCK_50 = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    ascii = 8'h00;
    logic [4:0]    mods = 5'b0;
    logic          pop = 1'b0;
    logic          clr_ovf = 1'b0;
    logic          irq_en = 1'b0;
    logic [15:0]   rd_data;
    logic          rd_valid;
    logic [AWL:0]  count;
    logic          overflow;
    logic          irq;

    kb_event_scheduler #(.DELAY_CYC(DLY), .REPEAT_CYC(RPT), .DEPTH(DEP), .AW(AWL)) dut (
        .CLOCK_50(CLOCK_50), .rst(rst), .ascii(ascii), .mods(mods), .pop(pop),
        .clr_ovf(clr_ovf), .irq_en(irq_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .count(count), .overflow(overflow), .irq(irq)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: events are scheduled by absolute due-cycle, FIFO is a queue
    int          cyc = 0;
    logic [7:0]  aq = 8'h00, code = 8'h00;
    logic [4:0]  mq = 5'b0;
    bit          active = 0;
    int          due = 0;
    logic [15:0] fq[$];
    bit          m_ovf = 0, m_irq = 0;
    int          log_c[$];
    logic [15:0] log_d[$];

    always @(posedge CLOCK_50) begin
        int          sz;
        bit          mpush, pop_ok;
        logic [15:0] pd;
        cyc++;
        if (rst) begin
            fq.delete();
            active = 0;
            m_ovf  = 0;
            m_irq  = 0;
            aq     = 8'h00;
            mq     = 5'b0;
        end else begin
            mpush = 0;
            pd    = {3'b000, mq, aq};
            if (mq[4]) begin
                active = 0;
            end else if (!active) begin
                if (aq != 8'h00) begin
                    mpush = 1; active = 1; code = aq; due = cyc + DLY;
                end
            end else if (aq == 8'h00) begin
                active = 0;
            end else if (aq != code) begin
                mpush = 1; code = aq; due = cyc + DLY;
            end else if (cyc == due) begin
                mpush = 1; due = cyc + RPT;
            end
            sz     = fq.size();
            pop_ok = pop && (sz > 0);
            m_irq  = irq_en && (sz > 0);
            if (pop_ok) void'(fq.pop_front());
            if (mpush) begin
                log_c.push_back(cyc);
                log_d.push_back(pd);
            end
            if (mpush && (sz < DEP || pop_ok)) fq.push_back(pd);
            if (mpush && !(sz < DEP || pop_ok)) m_ovf = 1;
            else if (clr_ovf) m_ovf = 0;
            aq = ascii;
            mq = mods;
        end
    end

    always @(negedge CLOCK_50) begin
        check("rd_valid", 32'(rd_valid), 32'(fq.size() > 0));
        check("rd_data", 32'(rd_data), (fq.size() > 0) ? 32'(fq[0]) : 32'h0);
        check("count", 32'(count), 32'(fq.size()));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("irq", 32'(irq), 32'(m_irq));
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    initial begin
        int base;
        int exp_a[6] = '{2, 12, 16, 20, 24, 28};
        int exp_b[3] = '{2, 7, 17};
        logic [15:0] dat_b[3] = '{16'h0061, 16'h0062, 16'h0062};

        tick(2);
        check("rst_count", 32'(count), 32'd0);
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_data", 32'(rd_data), 32'h0);
        rst = 1'b0;
        tick(1);

        // Held 'A' with continuous pop: event timing pinned by hand-computed cycles
        pop = 1'b1;
        log_c.delete(); log_d.delete();
        base = cyc; ascii = 8'h41;
        tick(30);
        ascii = 8'h00;
        tick(3);
        check("A_events", 32'(log_c.size()), 32'd6);
        for (int i = 0; i < log_c.size() && i < 6; i++) begin
            check("A_cycle", 32'(log_c[i] - base), 32'(exp_a[i]));
            check("A_data", 32'(log_d[i]), 32'h0041);
        end

        // 'a' then 'b' mid-delay
        log_c.delete(); log_d.delete();
        base = cyc; ascii = 8'h61;
        tick(5);
        ascii = 8'h62;
        tick(12);
        ascii = 8'h00;
        tick(3);
        pop = 1'b0;
        check("ab_events", 32'(log_c.size()), 32'd3);
        for (int i = 0; i < log_c.size() && i < 3; i++) begin
            check("ab_cycle", 32'(log_c[i] - base), 32'(exp_b[i]));
            check("ab_data", 32'(log_d[i]), 32'(dat_b[i]));
        end

        // Overflow: five distinct codes into a four-deep FIFO
        ascii = 8'h31; tick(1);
        ascii = 8'h32; tick(1);
        ascii = 8'h33; tick(1);
        ascii = 8'h34; tick(1);
        ascii = 8'h35; tick(1);
        ascii = 8'h00; tick(3);
        check("ovf_count", 32'(count), 32'd4);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_head", 32'(rd_data), 32'h0031);
        clr_ovf = 1'b1; tick(1); clr_ovf = 1'b0;
        check("ovf_clr", 32'(overflow), 32'd0);

        // Full FIFO: push and pop on the same edge
        ascii = 8'h36; tick(1);
        pop = 1'b1; tick(1);
        pop = 1'b0; ascii = 8'h00;
        tick(2);
        check("full_pp_count", 32'(count), 32'd4);
        check("full_pp_ovf", 32'(overflow), 32'd0);
        check("full_pp_head", 32'(rd_data), 32'h0032);
        pop = 1'b1; tick(3); pop = 1'b0;
        check("tail_data", 32'(rd_data), 32'h0036);
        check("tail_count", 32'(count), 32'd1);
        pop = 1'b1; tick(1); pop = 1'b0;
        check("drain_count", 32'(count), 32'd0);

        // Empty FIFO pops and irq
        irq_en = 1'b1;
        pop = 1'b1; tick(1); pop = 1'b0;
        check("empty_pop", 32'(count), 32'd0);
        ascii = 8'h37; tick(1);
        pop = 1'b1; tick(1);
        pop = 1'b0; ascii = 8'h00;
        check("empty_pp_count", 32'(count), 32'd1);
        check("irq_lag", 32'(irq), 32'd0);
        tick(1);
        check("irq_set", 32'(irq), 32'd1);
        pop = 1'b1; tick(1); pop = 1'b0;
        tick(1);

        // Error flag suppresses events
        ascii = 8'h42; mods = 5'b10000;
        tick(4);
        check("err_none", 32'(count), 32'd0);
        ascii = 8'h00; mods = 5'b00000;
        tick(2);
        check("err_after", 32'(count), 32'd0);

        // Reset while holding in REPEAT, key still held afterwards
        mods = 5'b00100; ascii = 8'h41;
        tick(17);
        check("pre_rst_count", 32'(count), 32'd3);
        check("pre_rst_head", 32'(rd_data), 32'h0441);
        rst = 1'b1; tick(1); rst = 1'b0;
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_irq", 32'(irq), 32'd0);
        tick(1);
        check("post_rst_c1", 32'(count), 32'd0);
        tick(1);
        check("post_rst_c2", 32'(count), 32'd1);
        check("post_rst_data", 32'(rd_data), 32'h0441);
        ascii = 8'h00; mods = 5'b0;
        tick(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
